// File: rtl/jtvigil_snd_latch_if.sv
// rtl/jtvigil_snd_latch_if.sv - sound Z80 I/O bus as seen by the sound latch
interface jtvigil_snd_latch_if;
  logic [7:0] snd_A;
  logic [7:0] snd_dout;
  logic       snd_iorq_n;
  logic       snd_rd_n;
  logic       snd_wr_n;
  logic       snd_m1_n;
  logic [7:0] io_din;
  logic       io_din_en;
  logic       wait_n;

  modport master (
    output snd_A, snd_dout, snd_iorq_n, snd_rd_n, snd_wr_n, snd_m1_n,
    input  io_din, io_din_en, wait_n
  );

  modport slave (
    input  snd_A, snd_dout, snd_iorq_n, snd_rd_n, snd_wr_n, snd_m1_n,
    output io_din, io_din_en, wait_n
  );
endinterface

// File: rtl/jtvigil_snd_latch.sv
// rtl/jtvigil_snd_latch.sv - main-to-sound command latch, IRQ vectoring and sample-ROM I/O page
module jtvigil_snd_latch (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [7:0]                main_dout,
  input  logic                      latch_wr,
  jtvigil_snd_latch_if.slave        snd,
  input  logic                      ym_irq_n,
  output logic                      int_n,
  output logic [7:0]                dac,
  output logic [15:0]               smp_addr,
  output logic                      smp_cs,
  input  logic [7:0]                smp_data,
  input  logic                      smp_ok
);

  typedef enum logic {FETCH, READY} fetch_t;

  fetch_t      state, state_d;
  logic [7:0]  cmd, smp_buf;
  logic        pend, ok_arm, buf_ld;
  logic        lwr_s, lwr_l, wr_s, wr_l, r4_s, r4_l;
  logic [2:0]  wr_a;
  logic [7:0]  wr_d;

  logic io_cyc, rd_act, wr_act, ack, rd4;
  logic latch_set, wr_fire, inc, addr_chg;
  logic unused_a;

  assign unused_a = ^snd.snd_A[6:3];

  assign io_cyc = ~snd.snd_iorq_n & snd.snd_m1_n & snd.snd_A[7];
  assign rd_act = io_cyc & ~snd.snd_rd_n;
  assign wr_act = io_cyc & ~snd.snd_wr_n;
  assign ack    = ~snd.snd_iorq_n & ~snd.snd_m1_n;
  assign rd4    = rd_act & (snd.snd_A[2:0] == 3'd4);

  // Writes act when the strobe starts; the read-4 increment waits for the
  // strobe to end so a stalled read never advances past the data it returns.
  assign latch_set = lwr_s & ~lwr_l;
  assign wr_fire   = wr_s & ~wr_l;
  assign inc       = r4_l & ~r4_s;
  assign addr_chg  = (wr_fire & ((wr_a == 3'd0) | (wr_a == 3'd1))) | inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lwr_s <= 1'b0;
      lwr_l <= 1'b0;
      wr_s  <= 1'b0;
      wr_l  <= 1'b0;
      r4_s  <= 1'b0;
      r4_l  <= 1'b0;
      wr_a  <= 3'd0;
      wr_d  <= 8'h00;
    end else begin
      lwr_s <= latch_wr;
      lwr_l <= lwr_s;
      wr_s  <= wr_act;
      wr_l  <= wr_s;
      r4_s  <= rd4;
      r4_l  <= r4_s;
      wr_a  <= snd.snd_A[2:0];
      wr_d  <= snd.snd_dout;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd  <= 8'h00;
      pend <= 1'b0;
    end else if (latch_set) begin
      cmd  <= main_dout;
      pend <= 1'b1;
    end else if (wr_fire && wr_a == 3'd3) begin
      pend <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp_addr <= 16'h0000;
      dac      <= 8'h00;
    end else if (wr_fire) begin
      case (wr_a)
        3'd0:    smp_addr[7:0]  <= wr_d;
        3'd1:    smp_addr[15:8] <= wr_d;
        3'd2:    dac            <= wr_d;
        default: ;
      endcase
    end else if (inc) begin
      smp_addr <= smp_addr + 16'd1;
    end
  end

  // ok_arm masks smp_ok during the first cycle after an address change,
  // which could still belong to the request for the previous address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= FETCH;
      ok_arm  <= 1'b0;
      smp_buf <= 8'h00;
    end else begin
      state  <= state_d;
      ok_arm <= ~addr_chg;
      if (buf_ld) smp_buf <= smp_data;
    end
  end

  always_comb begin
    state_d = state;
    buf_ld  = 1'b0;
    if (addr_chg) begin
      state_d = FETCH;
    end else if (state == FETCH && ok_arm && smp_ok) begin
      buf_ld  = 1'b1;
      state_d = READY;
    end
  end

  assign smp_cs     = (state == FETCH);
  assign int_n      = ~(pend | ~ym_irq_n);
  assign snd.wait_n = ~(rd4 & (state == FETCH));

  always_comb begin
    snd.io_din    = 8'hFF;
    snd.io_din_en = 1'b0;
    if (ack) begin
      snd.io_din    = {2'b11, ~pend, ym_irq_n, 4'hF};
      snd.io_din_en = 1'b1;
    end else if (rd_act) begin
      snd.io_din_en = 1'b1;
      case (snd.snd_A[2:0])
        3'd0:    snd.io_din = cmd;
        3'd4:    snd.io_din = smp_buf;
        default: snd.io_din = 8'hFF;
      endcase
    end
  end

endmodule
